// File: rtl/cuckoo_l1_sched_if.sv
// rtl/cuckoo_l1_sched_if.sv - lookup word handshake and host table-update port
interface cuckoo_l1_sched_if;
  // lookup word stream
  logic        in_valid;
  logic        in_ready;
  // host table-update request
  logic        cfg_req;
  logic        cfg_table;
  logic        cfg_nocase;
  logic [10:0] cfg_addr;
  logic [9:0]  cfg_data;
  logic        cfg_ack;
  logic        cfg_err;

  modport master (
    output in_valid, cfg_req, cfg_table, cfg_nocase, cfg_addr, cfg_data,
    input  in_ready, cfg_ack, cfg_err
  );

  modport slave (
    input  in_valid, cfg_req, cfg_table, cfg_nocase, cfg_addr, cfg_data,
    output in_ready, cfg_ack, cfg_err
  );
endinterface

// File: rtl/cuckoo_l1_sched.sv
// rtl/cuckoo_l1_sched.sv - Cuckoo L1 lookup sequencer with drained table-write arbitration
module cuckoo_l1_sched #(
  parameter int LAT        = 4,
  parameter int MIN_LOOKUP = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  cuckoo_l1_sched_if.slave        bus,
  output logic                    enable,
  output logic                    res_valid,
  output logic                    we_l1,
  output logic                    we_l1_nc,
  output logic                    we_t3,
  output logic                    we_t3_nc,
  output logic [10:0]             wr_addr,
  output logic [9:0]              wr_data,
  output logic                    busy
);

  // guard must be able to hold MIN_LOOKUP and stay at least 1 bit wide when it is 0
  localparam int GW = $clog2(MIN_LOOKUP + 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    WRITE = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [LAT-1:0]    vld_sr_q, vld_sr_d;
  logic [GW-1:0]     guard_q, guard_d;
  logic [10:0]       wr_addr_q, wr_addr_d;
  logic [9:0]        wr_data_q, wr_data_d;
  logic              sel_table_q, sel_table_d;
  logic              sel_nocase_q, sel_nocase_d;

  logic              guard_zero;
  logic              take_cfg;
  logic              addr_bad;

  assign guard_zero = (guard_q == '0);
  // a request is served only from IDLE once the lookup-priority window has expired
  assign take_cfg   = (state_q == IDLE) && bus.cfg_req && guard_zero;
  // T3 RAMs are only 512 deep: any upper address bit set rejects the write
  assign addr_bad   = sel_table_q && (wr_addr_q[10:9] != 2'b00);

  // state register and all datapath flops, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      vld_sr_q     <= '0;
      guard_q      <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      sel_table_q  <= 1'b0;
      sel_nocase_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vld_sr_q     <= vld_sr_d;
      guard_q      <= guard_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      sel_table_q  <= sel_table_d;
      sel_nocase_q <= sel_nocase_d;
    end
  end

  // next-state: wait for an empty pipeline before the single write cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (take_cfg) state_d = DRAIN;
      DRAIN:   if (vld_sr_q == '0) state_d = WRITE;
      WRITE:   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // token tracking, guard countdown and request capture
  always_comb begin
    vld_sr_d     = LAT'({vld_sr_q, enable});
    guard_d      = guard_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    sel_table_d  = sel_table_q;
    sel_nocase_d = sel_nocase_q;
    if (state_q == WRITE) begin
      guard_d = GW'(MIN_LOOKUP);
    end else if ((state_q == IDLE) && !guard_zero) begin
      guard_d = guard_q - 1'b1;
    end
    if (take_cfg) begin
      wr_addr_d    = bus.cfg_addr;
      wr_data_d    = bus.cfg_data;
      sel_table_d  = bus.cfg_table;
      sel_nocase_d = bus.cfg_nocase;
    end
  end

  // outputs: handshake, strobes and completion decoded from the current state
  always_comb begin
    bus.in_ready = (state_q == IDLE) && !(bus.cfg_req && guard_zero);
    enable       = bus.in_valid && bus.in_ready;
    res_valid    = vld_sr_q[LAT-1];
    busy         = (state_q != IDLE);
    we_l1        = 1'b0;
    we_l1_nc     = 1'b0;
    we_t3        = 1'b0;
    we_t3_nc     = 1'b0;
    bus.cfg_ack  = 1'b0;
    bus.cfg_err  = 1'b0;
    if ((state_q == WRITE) && !addr_bad) begin
      unique case ({sel_table_q, sel_nocase_q})
        2'b00:   we_l1    = 1'b1;
        2'b01:   we_l1_nc = 1'b1;
        2'b10:   we_t3    = 1'b1;
        default: we_t3_nc = 1'b1;
      endcase
    end
    if (state_q == ACK) begin
      bus.cfg_ack = 1'b1;
      bus.cfg_err = addr_bad;
    end
  end

  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_cuckoo_l1_sched.sv
// tb/tb_cuckoo_l1_sched.sv - directed self-checking bench for cuckoo_l1_sched
module tb_cuckoo_l1_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        enable, res_valid, busy;
  logic        we_l1, we_l1_nc, we_t3, we_t3_nc;
  logic [10:0] wr_addr;
  logic [9:0]  wr_data;
  logic [3:0]  we_vec;
  int          errors = 0;
  int          checks = 0;

  cuckoo_l1_sched_if bus_if ();

  cuckoo_l1_sched #(.LAT(4), .MIN_LOOKUP(16)) dut (
    .clk(clk), .rst(rst), .bus(bus_if),
    .enable(enable), .res_valid(res_valid),
    .we_l1(we_l1), .we_l1_nc(we_l1_nc), .we_t3(we_t3), .we_t3_nc(we_t3_nc),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  assign we_vec = {we_l1, we_l1_nc, we_t3, we_t3_nc};

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic req, input logic tbl, input logic nc,
                         input logic [10:0] addr, input logic [9:0] data);
    bus_if.cfg_req    = req;
    bus_if.cfg_table  = tbl;
    bus_if.cfg_nocase = nc;
    bus_if.cfg_addr   = addr;
    bus_if.cfg_data   = data;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus_if.in_valid = 1'b0;
    set_cfg(1'b0, 1'b0, 1'b0, 11'h0, 10'h0);
    repeat (3) cyc();
    #2;
    checks++;
    if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus_if.in_ready); end
    checks++;
    if ({enable, res_valid, busy} !== 3'b000) begin errors++; $display("FAIL reset_en_res_busy: got %b expected 000", {enable, res_valid, busy}); end
    checks++;
    if ({we_vec, bus_if.cfg_ack, bus_if.cfg_err} !== 6'b0) begin errors++; $display("FAIL reset_strobes: got %b expected 000000", {we_vec, bus_if.cfg_ack, bus_if.cfg_err}); end
    checks++;
    if ({wr_addr, wr_data} !== 21'h0) begin errors++; $display("FAIL reset_wr_regs: got %h expected 0", {wr_addr, wr_data}); end
  endtask

  task automatic test_stream();
    cyc();
    rst = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cyc();
      bus_if.in_valid = (k < 10);
      #2;
      checks++;
      if (enable !== (k < 10)) begin errors++; $display("FAIL stream_enable k=%0d: got %b expected %b", k, enable, (k < 10)); end
      checks++;
      if (res_valid !== (k >= 4 && k <= 13)) begin errors++; $display("FAIL stream_res_valid k=%0d: got %b expected %b", k, res_valid, (k >= 4 && k <= 13)); end
    end
  endtask

  task automatic test_cfg_l1();
    for (int j = 0; j < 6; j++) begin
      cyc();
      bus_if.in_valid = 1'b1;
    end
    cyc();
    set_cfg(1'b1, 1'b0, 1'b0, 11'h123, 10'h1AB);
    #2;
    checks++;
    if ({bus_if.in_ready, enable} !== 2'b00) begin errors++; $display("FAIL cfg_req_blocks_word: got %b expected 00", {bus_if.in_ready, enable}); end
    for (int k = 1; k <= 6; k++) begin
      cyc();
      #2;
      checks++;
      if (we_vec !== ((k == 5) ? 4'b1000 : 4'b0000)) begin errors++; $display("FAIL l1_we k=%0d: got %b expected %b", k, we_vec, ((k == 5) ? 4'b1000 : 4'b0000)); end
      checks++;
      if (bus_if.cfg_ack !== (k == 6)) begin errors++; $display("FAIL l1_ack k=%0d: got %b expected %b", k, bus_if.cfg_ack, (k == 6)); end
      if (k <= 4) begin
        checks++;
        if ({bus_if.in_ready, busy} !== 2'b01) begin errors++; $display("FAIL l1_drain k=%0d: got %b expected 01", k, {bus_if.in_ready, busy}); end
      end
      if (k == 5) begin
        checks++;
        if ({wr_addr, wr_data} !== {11'h123, 10'h1AB}) begin errors++; $display("FAIL l1_wr_regs: got %h/%h expected 123/1ab", wr_addr, wr_data); end
      end
      if (k == 6) begin
        checks++;
        if (bus_if.cfg_err !== 1'b0) begin errors++; $display("FAIL l1_err: got %b expected 0", bus_if.cfg_err); end
      end
    end
    cyc();
    bus_if.cfg_req = 1'b0;
    #2;
    checks++;
    if ({bus_if.in_ready, enable} !== 2'b11) begin errors++; $display("FAIL l1_resume: got %b expected 11", {bus_if.in_ready, enable}); end
  endtask

  task automatic test_guard();
    int cnt = 0;
    int n_ack = 0;
    int n_we = 0;
    cyc();
    bus_if.in_valid = 1'b1;
    set_cfg(1'b1, 1'b0, 1'b1, 11'h2AA, 10'h3FF);
    for (int c = 0; c < 120 && n_ack < 3; c++) begin
      cyc();
      #2;
      if (we_l1_nc) n_we++;
      if (bus_if.cfg_ack) begin
        if (n_ack > 0) begin
          checks++;
          if (cnt !== 16) begin errors++; $display("FAIL guard_words ack=%0d: got %0d expected 16", n_ack, cnt); end
        end
        cnt = 0;
        n_ack++;
      end else if (enable) begin
        cnt++;
      end
    end
    bus_if.cfg_req  = 1'b0;
    bus_if.in_valid = 1'b0;
    checks++;
    if (n_ack !== 3) begin errors++; $display("FAIL guard_ack_count: got %0d expected 3", n_ack); end
    checks++;
    if (n_we !== 3) begin errors++; $display("FAIL guard_we_count: got %0d expected 3", n_we); end
  endtask

  task automatic test_cfg_err();
    logic got = 1'b0;
    logic err = 1'b0;
    logic we_seen = 1'b0;
    cyc();
    bus_if.in_valid = 1'b0;
    set_cfg(1'b1, 1'b1, 1'b0, 11'h600, 10'h2AA);
    for (int c = 0; c < 60 && !got; c++) begin
      cyc();
      #2;
      if (we_vec != 4'b0) we_seen = 1'b1;
      if (bus_if.cfg_ack) begin
        got = 1'b1;
        err = bus_if.cfg_err;
      end
    end
    bus_if.cfg_req = 1'b0;
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL err_ack_seen: got %b expected 1", got); end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_flag: got %b expected 1", err); end
    checks++;
    if (we_seen !== 1'b0) begin errors++; $display("FAIL err_no_strobe: got %b expected 0", we_seen); end
  endtask

  task automatic test_idle_t3nc();
    repeat (20) cyc();
    cyc();
    set_cfg(1'b1, 1'b1, 1'b1, 11'h0FF, 10'h155);
    #2;
    checks++;
    if ({bus_if.in_ready, busy} !== 2'b00) begin errors++; $display("FAIL t3nc_req_cycle: got %b expected 00", {bus_if.in_ready, busy}); end
    cyc();
    set_cfg(1'b1, 1'b0, 1'b0, 11'h7FF, 10'h000);
    #2;
    checks++;
    if ({busy, we_vec} !== 5'b10000) begin errors++; $display("FAIL t3nc_drain: got %b expected 10000", {busy, we_vec}); end
    cyc();
    #2;
    checks++;
    if (we_vec !== 4'b0001) begin errors++; $display("FAIL t3nc_we: got %b expected 0001", we_vec); end
    checks++;
    if ({wr_addr, wr_data} !== {11'h0FF, 10'h155}) begin errors++; $display("FAIL t3nc_wr_regs: got %h/%h expected 0ff/155", wr_addr, wr_data); end
    cyc();
    #2;
    checks++;
    if ({bus_if.cfg_ack, bus_if.cfg_err} !== 2'b10) begin errors++; $display("FAIL t3nc_ack: got %b expected 10", {bus_if.cfg_ack, bus_if.cfg_err}); end
    cyc();
    bus_if.cfg_req = 1'b0;
  endtask

  task automatic test_reset_write();
    logic seen = 1'b0;
    repeat (20) cyc();
    cyc();
    set_cfg(1'b1, 1'b0, 1'b1, 11'h055, 10'h0AA);
    cyc();
    #2;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rstw_drain_busy: got %b expected 1", busy); end
    cyc();
    rst = 1'b0;
    bus_if.cfg_req = 1'b0;
    #1;
    checks++;
    if ({we_vec, busy} !== 5'b0) begin errors++; $display("FAIL rstw_async: got %b expected 00000", {we_vec, busy}); end
    repeat (3) begin
      cyc();
      #2;
      if ({we_vec, bus_if.cfg_ack} != 5'b0) seen = 1'b1;
    end
    cyc();
    rst = 1'b1;
    repeat (4) begin
      cyc();
      #2;
      if ({we_vec, bus_if.cfg_ack} != 5'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rstw_no_strobe_ack: got %b expected 0", seen); end
    checks++;
    if ({bus_if.in_ready, busy} !== 2'b10) begin errors++; $display("FAIL rstw_after: got %b expected 10", {bus_if.in_ready, busy}); end
    checks++;
    if ({wr_addr, wr_data} !== 21'h0) begin errors++; $display("FAIL rstw_wr_regs: got %h expected 0", {wr_addr, wr_data}); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_cfg_l1();
    test_guard();
    test_cfg_err();
    test_idle_t3nc();
    test_reset_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
